// File: rtl/reg_file_pkg.sv
// Shared definitions for the register-file command sequencer: op codes,
// FSM state encoding and default datapath widths.
package reg_file_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

endpackage

// File: rtl/reg_file_seq_if.sv
// Command channel between the command source and the sequencer, including
// the retire status (done/result/flags) returned to the source.
interface reg_file_seq_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both 1; the source holds all cmd_* fields stable while
  // cmd_valid=1 and cmd_ready=0, and may drop cmd_valid only after transfer.
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_rd;
  logic [ADDR_W-1:0] cmd_rs1;
  logic [ADDR_W-1:0] cmd_rs2;
  logic [DATA_W-1:0] cmd_imm;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              flag_z;
  logic              flag_c;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
    input  cmd_ready, done, result, flag_z, flag_c
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
    output cmd_ready, done, result, flag_z, flag_c
  );

endinterface

// File: rtl/reg_file_alu.sv
// Combinational ALU for the sequencer's EXEC step; the top bit of value is
// the carry (ADD) or borrow (SUB), zero for all other operations.
module reg_file_alu
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W:0]   value
);

  always_comb begin
    value = '0;
    case (op)
      OP_ADD:  value = {1'b0, a} + {1'b0, b};
      OP_SUB:  value = {(a < b), a - b};
      OP_AND:  value = {1'b0, a & b};
      OP_OR:   value = {1'b0, a | b};
      OP_XOR:  value = {1'b0, a ^ b};
      OP_MOV:  value = {1'b0, a};
      OP_LDI:  value = {1'b0, imm};
      default: value = '0;
    endcase
  end

endmodule

// File: rtl/reg_file_seq.sv
// Sequencer running one register-to-register command at a time as
// READ -> EXEC -> WB, sharing the register file write port with debug writes.
module reg_file_seq
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  reg_file_seq_if.slave     cmd,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              dbg_gnt,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [ADDR_W-1:0] rf_rd_addr1,
  output logic [ADDR_W-1:0] rf_rd_addr2,
  input  logic [DATA_W-1:0] rf_rd_data1,
  input  logic [DATA_W-1:0] rf_rd_data2,
  output state_t            seq_state
);

  state_t            state;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [ADDR_W-1:0] rs1_q;
  logic [ADDR_W-1:0] rs2_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W:0]   exec_q;
  logic [DATA_W:0]   alu_value;
  logic              done_q;
  logic [DATA_W-1:0] result_q;
  logic              flag_z_q;
  logic              flag_c_q;
  logic              seq_we;

  reg_file_alu #(.DATA_W(DATA_W)) u_alu (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .imm   (imm_q),
    .value (alu_value)
  );

  assign cmd.cmd_ready = (state == IDLE) & ~rst;
  assign cmd.done      = done_q;
  assign cmd.result    = result_q;
  assign cmd.flag_z    = flag_z_q;
  assign cmd.flag_c    = flag_c_q;
  assign seq_state     = state;
  assign rf_rd_addr1   = rs1_q;
  assign rf_rd_addr2   = rs2_q;

  // The sequencer owns the write port in WB (even for NOP); debug waits there.
  assign dbg_gnt = dbg_req & (state != WB) & ~rst;
  assign seq_we  = (state == WB) & (op_q != OP_NOP) & ~rst;

  always_comb begin
    rf_we      = 1'b0;
    rf_wr_addr = rd_q;
    rf_wr_data = exec_q[DATA_W-1:0];
    if (seq_we) begin
      rf_we = 1'b1;
    end else if (dbg_gnt) begin
      rf_we      = 1'b1;
      rf_wr_addr = dbg_addr;
      rf_wr_data = dbg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= OP_NOP;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      exec_q   <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd.cmd_valid && cmd.cmd_ready) begin
            op_q  <= cmd.cmd_op;
            rd_q  <= cmd.cmd_rd;
            rs1_q <= cmd.cmd_rs1;
            rs2_q <= cmd.cmd_rs2;
            imm_q <= cmd.cmd_imm;
            state <= READ;
          end
        end
        READ: begin
          // A same-cycle debug write lands after this edge, so the old value is captured.
          a_q   <= rf_rd_data1;
          b_q   <= rf_rd_data2;
          state <= EXEC;
        end
        EXEC: begin
          exec_q <= alu_value;
          done_q <= 1'b1;
          state  <= WB;
        end
        WB: begin
          if (op_q != OP_NOP) begin
            result_q <= exec_q[DATA_W-1:0];
            flag_z_q <= (exec_q[DATA_W-1:0] == '0);
            flag_c_q <= exec_q[DATA_W];
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_seq.sv
// Directed bench for reg_file_seq with a behavioural 8x8 register file,
// a shadow register model and an expected-result queue.
module tb_reg_file_seq;
  import reg_file_pkg::*;

  localparam int DW = 8;
  localparam int AW = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          dbg_req;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;
  logic          dbg_gnt;
  logic          rf_we;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_wr_data;
  logic [AW-1:0] rf_rd_addr1;
  logic [AW-1:0] rf_rd_addr2;
  logic [DW-1:0] rf_rd_data1;
  logic [DW-1:0] rf_rd_data2;
  state_t        seq_state;

  reg_file_seq_if #(.DATA_W(DW), .ADDR_W(AW)) cmd_if ();

  reg_file_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cmd_if),
    .dbg_req     (dbg_req),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .dbg_gnt     (dbg_gnt),
    .rf_we       (rf_we),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data),
    .rf_rd_addr1 (rf_rd_addr1),
    .rf_rd_addr2 (rf_rd_addr2),
    .rf_rd_data1 (rf_rd_data1),
    .rf_rd_data2 (rf_rd_data2),
    .seq_state   (seq_state)
  );

  // register file: combinational reads, synchronous write, not reset
  logic [DW-1:0] rf_mem [2**AW];
  always_ff @(posedge clk) if (rf_we) rf_mem[rf_wr_addr] <= rf_wr_data;
  assign rf_rd_data1 = rf_mem[rf_rd_addr1];
  assign rf_rd_data2 = rf_mem[rf_rd_addr2];

  // scoreboard: {carry, zero, result} per command, plus {op, rd}
  logic [DW+1:0] exp_q[$];
  logic [5:0]    meta_q[$];
  logic [DW+1:0] last_exp;
  logic [DW-1:0] shadow [2**AW];
  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW+1:0] model(input logic [2:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b, input logic [DW-1:0] imm,
                                          input logic [DW+1:0] prev);
    logic [DW:0] v;
    case (op)
      3'b000:  v = {1'b0, a} + {1'b0, b};
      3'b001:  v = {(a < b), DW'(a - b)};
      3'b010:  v = {1'b0, a & b};
      3'b011:  v = {1'b0, a | b};
      3'b100:  v = {1'b0, a ^ b};
      3'b101:  v = {1'b0, a};
      3'b110:  v = {1'b0, imm};
      default: return prev;
    endcase
    return {v[DW], (v[DW-1:0] == '0), v[DW-1:0]};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    dbg_req = 1'b1; dbg_addr = a; dbg_data = d;
    #1;
    check("dbg_gnt_idle", dbg_gnt, 1);
    tick();
    dbg_req = 1'b0;
    shadow[a] = d;
  endtask

  task automatic push_cmd(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                          input logic [AW-1:0] rs2, input logic [DW-1:0] imm);
    logic [DW+1:0] e;
    e = model(op, shadow[rs1], shadow[rs2], imm, last_exp);
    exp_q.push_back(e);
    meta_q.push_back({op, rd});
    last_exp = e;
  endtask

  task automatic drive_cmd(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                           input logic [AW-1:0] rs2, input logic [DW-1:0] imm);
    cmd_if.cmd_op = op; cmd_if.cmd_rd = rd; cmd_if.cmd_rs1 = rs1;
    cmd_if.cmd_rs2 = rs2; cmd_if.cmd_imm = imm;
  endtask

  task automatic accept(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                        input logic [AW-1:0] rs2, input logic [DW-1:0] imm);
    push_cmd(op, rd, rs1, rs2, imm);
    drive_cmd(op, rd, rs1, rs2, imm);
    cmd_if.cmd_valid = 1'b1;
    #1;
    check("accept_ready", cmd_if.cmd_ready, 1);
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic retire_check(input string tag);
    logic [DW+1:0] e;
    logic [5:0]    m;
    check({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    m = meta_q.pop_front();
    check({tag, "_result"}, cmd_if.result, e[DW-1:0]);
    check({tag, "_flag_z"}, cmd_if.flag_z, e[DW]);
    check({tag, "_flag_c"}, cmd_if.flag_c, e[DW+1]);
    if (m[5:3] != OP_NOP) shadow[m[2:0]] = e[DW-1:0];
    check({tag, "_rf"}, rf_mem[m[2:0]], shadow[m[2:0]]);
  endtask

  // Called in the READ cycle, one tick after the accept edge.
  task automatic collect(input string tag);
    int cyc;
    logic [5:0] m;
    cyc = 1;
    #1;
    while (cmd_if.done !== 1'b1 && cyc < 8) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    check({tag, "_latency"}, cyc, 3);
    m = (meta_q.size() != 0) ? meta_q[0] : 6'd0;
    check({tag, "_we"}, rf_we, (m[5:3] != OP_NOP));
    check({tag, "_ready_wb"}, cmd_if.cmd_ready, 0);
    @(posedge clk);
    #2;
    check({tag, "_done_pulse"}, cmd_if.done, 0);
    retire_check(tag);
  endtask

  logic [2:0]    b2b_op  [3];
  logic [AW-1:0] b2b_rd  [3];
  logic [AW-1:0] b2b_rs1 [3];
  logic [AW-1:0] b2b_rs2 [3];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, cyc, last_acc, retired;
    logic pend;
    last_exp = '0;
    rst = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    drive_cmd(OP_NOP, 0, 0, 0, 0);
    dbg_req = 1'b1; dbg_addr = 3'd0; dbg_data = 8'h00;

    // reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_if.cmd_ready, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_dbg_gnt", dbg_gnt, 0);
    dbg_req = 1'b0;
    rst = 1'b0;
    #1;
    check("init_done", cmd_if.done, 0);
    check("init_result", cmd_if.result, 0);
    check("init_flag_z", cmd_if.flag_z, 0);
    check("init_flag_c", cmd_if.flag_c, 0);
    check("init_state", seq_state, IDLE);
    check("init_ready", cmd_if.cmd_ready, 1);

    // ADD with carry out
    dbg_write(3'd1, 8'h0F);
    dbg_write(3'd2, 8'hF3);
    accept(OP_ADD, 3'd3, 3'd1, 3'd2, 8'h00);
    collect("add");
    check("add_r3_const", rf_mem[3], 8'h02);
    check("add_c_const", cmd_if.flag_c, 1);

    // SUB to zero, SUB with borrow
    accept(OP_SUB, 3'd4, 3'd1, 3'd1, 8'h00);
    collect("sub_zero");
    check("sub_zero_z_const", cmd_if.flag_z, 1);
    accept(OP_SUB, 3'd5, 3'd1, 3'd2, 8'h00);
    collect("sub_borrow");
    check("sub_borrow_const", cmd_if.result, 8'h1C);

    // debug held across a command; write to rs1 during READ
    accept(OP_ADD, 3'd6, 3'd1, 3'd2, 8'h00);
    dbg_req = 1'b1; dbg_addr = 3'd1; dbg_data = 8'h55;
    #1;
    check("hz_gnt_read", dbg_gnt, 1);
    check("hz_state_read", seq_state, READ);
    tick(); #1;
    check("hz_gnt_exec", dbg_gnt, 1);
    tick(); #1;
    check("hz_done_wb", cmd_if.done, 1);
    check("hz_gnt_wb", dbg_gnt, 0);
    check("hz_wr_addr_wb", rf_wr_addr, 6);
    check("hz_wr_data_wb", rf_wr_data, 8'h02);
    tick(); #1;
    check("hz_gnt_retry", dbg_gnt, 1);
    check("hz_wr_addr_retry", rf_wr_addr, 1);
    retire_check("hz");
    tick();
    dbg_req = 1'b0;
    shadow[1] = 8'h55;
    #1;
    check("hz_r1_after", rf_mem[1], 8'h55);
    check("hz_r6_old_operand", rf_mem[6], 8'h02);

    // earlier debug write is visible
    accept(OP_MOV, 3'd0, 3'd1, 3'd0, 8'h00);
    collect("mov");
    check("mov_const", cmd_if.result, 8'h55);

    // LDI then NOP
    accept(OP_LDI, 3'd7, 3'd0, 3'd0, 8'hA5);
    collect("ldi");
    accept(OP_NOP, 3'd7, 3'd1, 3'd2, 8'h00);
    collect("nop");
    check("nop_r7_const", rf_mem[7], 8'hA5);
    check("nop_result_const", cmd_if.result, 8'hA5);

    // back-to-back with cmd_valid held
    b2b_op  = '{OP_OR, OP_AND, OP_XOR};
    b2b_rd  = '{3'd5, 3'd6, 3'd0};
    b2b_rs1 = '{3'd1, 3'd5, 3'd6};
    b2b_rs2 = '{3'd2, 3'd7, 3'd6};
    k = 0; cyc = 0; last_acc = -1; retired = 0; pend = 1'b0;
    while (retired < 3 && cyc < 60) begin
      if (k < 3) begin
        cmd_if.cmd_valid = 1'b1;
        drive_cmd(b2b_op[k], b2b_rd[k], b2b_rs1[k], b2b_rs2[k], 8'h00);
      end else begin
        cmd_if.cmd_valid = 1'b0;
      end
      #1;
      if (pend) begin
        retire_check("b2b");
        retired++;
        pend = 1'b0;
      end
      if (cmd_if.done === 1'b1) begin
        check("b2b_we", rf_we, 1);
        pend = 1'b1;
      end
      if (cmd_if.cmd_ready === 1'b1 && k < 3) begin
        if (last_acc >= 0) check("b2b_gap", cyc - last_acc, 4);
        push_cmd(b2b_op[k], b2b_rd[k], b2b_rs1[k], b2b_rs2[k], 8'h00);
        last_acc = cyc;
        k++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    cmd_if.cmd_valid = 1'b0;
    check("b2b_accepts", k, 3);
    check("b2b_retired", retired, 3);
    check("b2b_sb_empty", exp_q.size(), 0);
    check("b2b_r5_const", rf_mem[5], 8'hF7);
    check("b2b_r0_const", rf_mem[0], 8'h00);

    // reset during EXEC aborts the command
    drive_cmd(OP_ADD, 3'd4, 3'd1, 3'd2, 8'h00);
    cmd_if.cmd_valid = 1'b1;
    #1;
    tick();
    cmd_if.cmd_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("rstx_state", seq_state, EXEC);
    check("rstx_we", rf_we, 0);
    check("rstx_ready", cmd_if.cmd_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    check("rstx_ready_after", cmd_if.cmd_ready, 1);
    check("rstx_done", cmd_if.done, 0);
    check("rstx_result", cmd_if.result, 0);
    check("rstx_flag_z", cmd_if.flag_z, 0);
    check("rstx_flag_c", cmd_if.flag_c, 0);
    check("rstx_r4_kept", rf_mem[4], shadow[4]);
    last_exp = '0;
    tick();
    check("rstx_done_late", cmd_if.done, 0);

    // normal operation after the abort
    accept(OP_ADD, 3'd4, 3'd1, 3'd2, 8'h00);
    collect("post_rst");
    check("post_rst_const", rf_mem[4], 8'h48);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_file_seq.md
Name: reg_file_seq

Overview:
Sequencer for the 8-entry register file. It accepts single register-to-register commands (ALU op, rd, rs1, rs2, imm) over a valid/ready handshake. Each command is run as read, execute and writeback against the register file's two combinational read ports and its one synchronous write port. A secondary debug write requester shares the write port through fixed-priority arbitration. The block sits between the command source (test harness or future decoder) and the register file instance.

Parameters:
DATA_W, 8, register and datapath width
ADDR_W, 3, register address width (2**ADDR_W registers)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  block can accept a command
cmd_op  in  3  operation code (see Behaviour)
cmd_rd  in  ADDR_W  destination register
cmd_rs1  in  ADDR_W  source register 1
cmd_rs2  in  ADDR_W  source register 2
cmd_imm  in  DATA_W  immediate for LDI
done  out  1  one-cycle pulse: command retired
result  out  DATA_W  value written (held until next retire)
flag_z  out  1  last result == 0
flag_c  out  1  carry (ADD) / borrow (SUB)
dbg_req  in  1  debug write request
dbg_addr  in  ADDR_W  debug write address
dbg_data  in  DATA_W  debug write data
dbg_gnt  out  1  debug write performed this edge
rf_we  out  1  to reg file write enable
rf_wr_addr  out  ADDR_W  to reg file write address
rf_wr_data  out  DATA_W  to reg file write data
rf_rd_addr1  out  ADDR_W  to reg file read address 1
rf_rd_addr2  out  ADDR_W  to reg file read address 2
rf_rd_data1  in  DATA_W  from reg file read data 1
rf_rd_data2  in  DATA_W  from reg file read data 2

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; done, result, flag_z and flag_c clear to 0; latched command cleared. While rst=1: cmd_ready=0, rf_we=0, dbg_gnt=0. Reset mid-command aborts it and issues no write.
- FSM: IDLE -> READ -> EXEC -> WB -> IDLE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch op, rd, rs1, rs2 and imm, then go to READ. cmd_ready=0 in all other states.
- READ: rf_rd_addr1/2 = latched rs1/rs2. Latch rf_rd_data1/2 as operands A and B at the edge. In other states the read addresses still show the latched rs1/rs2.
- EXEC: compute into a DATA_W+1 bit internal result register.
  - 000 ADD: A+B, carry = bit DATA_W of the sum.
  - 001 SUB: A-B modulo 2**DATA_W, carry = (A<B).
  - 010 AND, 011 OR, 100 XOR, 101 MOV (=A), 110 LDI (=imm): carry=0.
  - 111 NOP: no write.
- WB: rf_we=1 (0 for NOP), rf_wr_addr=rd, rf_wr_data=value. done=1 for exactly this cycle. result, flag_z and flag_c update at the WB edge; NOP holds all three.
- Latency: accept edge at cycle 0; done is high in cycle 3 and the register is written at the end of cycle 3. Throughput is one command per 4 cycles, and the next command can be accepted in the cycle after WB.
- Arbitration: dbg_gnt = dbg_req & (state!=WB) & ~rst, combinational. When granted, rf_we/addr/data carry the debug write. In WB the sequencer wins; debug holds dbg_req and retries.
- Hazard: a debug write in a READ cycle to a register being read does not affect the latched operand (the old value is read). A debug write granted earlier is visible.
- rd==rs1 is legal: the write uses the operand latched in READ.
- Widths are unsigned with wrap-around, and there is no overflow flag.

Decomposition:
- Shared package reg_file_pkg: op-code localparams (OP_ADD..OP_NOP), FSM state encoding (IDLE/READ/EXEC/WB, 2 bits), DATA_W/ADDR_W defaults.
- Sub-module reg_file_alu: combinational; inputs op, A, B and imm; outputs a DATA_W+1 bit value. It is instantiated once in EXEC.
- The bench instantiates reg_file_seq together with the existing register file.

Test Plan:
- Debug writes r1=8'h0F and r2=8'hF3 (dbg_gnt=1 each cycle) then ADD r3,r1,r2 -> done in cycle 3, result=8'h02, flag_c=1, flag_z=0, r3 reads 8'h02.
- SUB r4,r1,r1 -> result=8'h00, flag_z=1, flag_c=0. SUB r5,r1,r2 -> result=8'h1C, flag_c=1.
- dbg_req held high across a command -> dbg_gnt=0 only in the WB cycle. A debug write to rs1 during READ leaves the latched operand at the old value. The debug write completes one cycle after WB.
- LDI r7,imm=8'hA5 then NOP -> r7=8'hA5. The NOP pulses done with rf_we=0, and result and flags hold.
- cmd_valid held with back-to-back commands -> cmd_ready high only in IDLE, one accept per 4 cycles, no command lost or duplicated.
- rst asserted in the EXEC cycle -> no rf_we, done=0, result and flags 0, cmd_ready=1 the cycle after rst drops.
